// File: rtl/cond_unit_if.sv
// Decoder/ALU-side bundle feeding the conditional-execution stage and its gated strobes.
interface cond_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       CondEx;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags
  );
endinterface

// File: rtl/cond_unit.sv
// ARM conditional-execution stage: NZCV register, condition decode, and write-strobe gating.
module cond_unit #(
  parameter logic [3:0] FLAG_RESET  = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b0
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave cu
);
  logic [3:0] flags;
  logic       n, z, c, v;
  logic       condex;
  logic       live;

  assign {n, z, c, v} = flags;

  // Decode uses only the stored flags; ALUFlags of this cycle never bypass in.
  always_comb begin
    condex = 1'b0;
    case (cu.Cond)
      4'b0000: condex = z;
      4'b0001: condex = !z;
      4'b0010: condex = c;
      4'b0011: condex = !c;
      4'b0100: condex = n;
      4'b0101: condex = !n;
      4'b0110: condex = v;
      4'b0111: condex = !v;
      4'b1000: condex = c & !z;
      4'b1001: condex = !c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = !z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      4'b1111: condex = NV_EXECUTES;
      default: condex = 1'b0;
    endcase
  end

  assign live = reset & !cu.Stall & condex;

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags <= FLAG_RESET;
    end else if (!cu.Stall && condex) begin
      if (cu.FlagW[1]) flags[3:2] <= cu.ALUFlags[3:2];
      if (cu.FlagW[0]) flags[1:0] <= cu.ALUFlags[1:0];
    end
  end

  assign cu.CondEx   = condex;
  assign cu.PCSrc    = cu.PCS & live;
  assign cu.RegWrite = cu.RegW & !cu.NoWrite & live;
  assign cu.MemWrite = cu.MemW & live;
  assign cu.Flags    = flags;
endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: condition-decode table plus reset/stall/partial-write sequences.
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  cond_unit_if cu ();

  cond_unit #(.FLAG_RESET(4'b0000), .NV_EXECUTES(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .cu    (cu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
    string      name;
  } vec_t;

  vec_t vecs [0:22];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs change #1 after the rising edge; checks happen later in the same low phase.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cu.Cond = 4'b1110; cu.ALUFlags = 4'b0000; cu.FlagW = 2'b00;
    cu.PCS = 1'b0; cu.RegW = 1'b0; cu.MemW = 1'b0;
    cu.NoWrite = 1'b0; cu.Stall = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    idle();
    cu.FlagW = 2'b11; cu.ALUFlags = f;
    step();
    cu.FlagW = 2'b00;
  endtask

  initial begin
    vecs = '{
      '{4'b0100, 4'b0000, 1'b1, "EQ z1"},
      '{4'b0000, 4'b0000, 1'b0, "EQ z0"},
      '{4'b0000, 4'b0001, 1'b1, "NE z0"},
      '{4'b0010, 4'b0010, 1'b1, "CS c1"},
      '{4'b0000, 4'b0011, 1'b1, "CC c0"},
      '{4'b1000, 4'b0100, 1'b1, "MI n1"},
      '{4'b0000, 4'b0101, 1'b1, "PL n0"},
      '{4'b0001, 4'b0110, 1'b1, "VS v1"},
      '{4'b0001, 4'b0111, 1'b0, "VC v1"},
      '{4'b0010, 4'b1000, 1'b1, "HI c1z0"},
      '{4'b0110, 4'b1000, 1'b0, "HI c1z1"},
      '{4'b0110, 4'b1001, 1'b1, "LS c1z1"},
      '{4'b1001, 4'b1010, 1'b1, "GE 1001"},
      '{4'b1001, 4'b1100, 1'b1, "GT 1001"},
      '{4'b1000, 4'b1011, 1'b1, "LT 1000"},
      '{4'b1000, 4'b1101, 1'b1, "LE 1000"},
      '{4'b0100, 4'b1010, 1'b1, "GE 0100"},
      '{4'b0100, 4'b1100, 1'b0, "GT 0100"},
      '{4'b0100, 4'b1101, 1'b1, "LE 0100"},
      '{4'b0000, 4'b1100, 1'b1, "GT 0000"},
      '{4'b0000, 4'b1110, 1'b1, "AL"},
      '{4'b1111, 4'b1111, 1'b0, "NV"},
      '{4'b1000, 4'b1010, 1'b0, "GE 1000"}
    };

    // Reset held two cycles with an all-ones flag write pending.
    reset = 1'b0;
    idle();
    cu.FlagW = 2'b11; cu.ALUFlags = 4'b1111; cu.RegW = 1'b1;
    #1;
    chk("rst regwrite pre-edge", {3'b0, cu.RegWrite}, 4'b0);
    step(); step();
    chk("rst flags", cu.Flags, 4'b0000);
    chk("rst regwrite", {3'b0, cu.RegWrite}, 4'b0);
    chk("rst pcsrc/memwrite", {2'b0, cu.PCSrc, cu.MemWrite}, 4'b0);
    reset = 1'b1;
    #1;
    chk("release regwrite", {3'b0, cu.RegWrite}, 4'b1);

    // Settle to a known state before the vectors.
    step();
    set_flags(4'b0000);

    // Condition decode table.
    for (int i = 0; i <= 22; i++) begin
      set_flags(vecs[i].flags);
      chk({"load ", vecs[i].name}, cu.Flags, vecs[i].flags);
      cu.Cond = vecs[i].cond; cu.PCS = 1'b1;
      #1;
      chk({"condex ", vecs[i].name}, {3'b0, cu.CondEx}, {3'b0, vecs[i].exp});
      chk({"pcsrc ", vecs[i].name}, {3'b0, cu.PCSrc}, {3'b0, vecs[i].exp});
      cu.PCS = 1'b0;
    end

    // CMP then BEQ, taken.
    idle();
    cu.FlagW = 2'b11; cu.NoWrite = 1'b1; cu.RegW = 1'b1; cu.ALUFlags = 4'b0110;
    #1;
    chk("cmp regwrite", {3'b0, cu.RegWrite}, 4'b0);
    step();
    chk("cmp flags", cu.Flags, 4'b0110);
    idle();
    cu.Cond = 4'b0000; cu.PCS = 1'b1;
    #1;
    chk("beq condex", {3'b0, cu.CondEx}, 4'b1);
    chk("beq pcsrc", {3'b0, cu.PCSrc}, 4'b1);
    step();

    // CMP then BEQ, not taken.
    idle();
    cu.FlagW = 2'b11; cu.NoWrite = 1'b1; cu.RegW = 1'b1; cu.ALUFlags = 4'b1000;
    step();
    chk("cmp2 flags", cu.Flags, 4'b1000);
    idle();
    cu.Cond = 4'b0000; cu.PCS = 1'b1;
    #1;
    chk("beq2 pcsrc", {3'b0, cu.PCSrc}, 4'b0);
    step();

    // Partial writes.
    set_flags(4'b1111);
    cu.FlagW = 2'b10; cu.ALUFlags = 4'b0000;
    step();
    chk("partial nz", cu.Flags, 4'b0011);
    cu.FlagW = 2'b01; cu.ALUFlags = 4'b0010;
    step();
    chk("partial cv", cu.Flags, 4'b0010);

    // Failed condition suppresses flag write and strobes.
    idle();
    cu.Cond = 4'b0000; cu.FlagW = 2'b11; cu.ALUFlags = 4'b0100; cu.MemW = 1'b1;
    #1;
    chk("failcond memwrite", {3'b0, cu.MemWrite}, 4'b0);
    step();
    chk("failcond flags", cu.Flags, 4'b0010);

    // Stall holds flags and blocks strobes.
    idle();
    cu.FlagW = 2'b11; cu.ALUFlags = 4'b1010; cu.Stall = 1'b1;
    cu.PCS = 1'b1; cu.RegW = 1'b1; cu.MemW = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall strobes", {1'b0, cu.PCSrc, cu.RegWrite, cu.MemWrite}, 4'b0);
      step();
      chk("stall flags", cu.Flags, 4'b0010);
    end
    cu.Stall = 1'b0;
    #1;
    chk("unstall strobes", {1'b0, cu.PCSrc, cu.RegWrite, cu.MemWrite}, 4'b0111);
    step();
    chk("unstall flags", cu.Flags, 4'b1010);

    // Unknown condition with no flag write leaves flags alone.
    idle();
    cu.Cond = 4'bxxxx;
    step();
    chk("x cond flags", cu.Flags, 4'b1010);

    // Reset mid-instruction drops the pending write.
    idle();
    cu.FlagW = 2'b11; cu.ALUFlags = 4'b1111; cu.MemW = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst memwrite", {3'b0, cu.MemWrite}, 4'b0);
    chk("midrst flags pre-edge", cu.Flags, 4'b1010);
    step();
    chk("midrst flags", cu.Flags, 4'b0000);
    reset = 1'b1;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage that sits directly downstream of the ALU in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and updates it from the ALU's 4-bit ALUFlags bus {N,Z,C,V}.
- Evaluates each instruction's 4-bit condition field against the stored flags.
- Gates the decoder's PCS/RegW/MemW strobes so only instructions whose condition passes can change architectural state.

Parameters:
- FLAG_RESET, 4'b0000, value loaded into the {N,Z,C,V} register on reset.
- NV_EXECUTES, 0, behaviour of cond 4'b1111: 0 = never execute, 1 = execute unconditionally.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} produced by the ALU for the current instruction.
- FlagW  input  2  flag write request: [1] writes N,Z; [0] writes C,V.
- PCS  input  1  decoder request to write the PC (branch or write to R15).
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  compare-class instruction (CMP/CMN/TST/TEQ): flags only, no Rd write.
- Stall  input  1  hold: the current instruction must not commit this cycle.
- CondEx  output  1  condition passed, computed from the stored flags.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- Flags  output  4  current stored {N,Z,C,V}.

Behaviour:
- Flag register: 4 flops.
  - On a rising edge with reset=0, load FLAG_RESET.
  - Otherwise, if Stall=0 and CondEx=1:
    - FlagW[1]=1 loads N,Z from ALUFlags[3:2].
    - FlagW[0]=1 loads C,V from ALUFlags[1:0].
  - Fields not written hold their value.
  - Stall=1 or CondEx=0 holds all four flags.
- CondEx is combinational from the stored (pre-update) flags only; it never depends on ALUFlags in the same cycle. No same-cycle bypass.
- Condition decode (N,Z,C,V = stored flags):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111 NV: NV_EXECUTES
- Gated outputs (combinational, zero latency), with live = reset & !Stall & CondEx:
  - PCSrc = PCS & live
  - RegWrite = RegW & !NoWrite & live
  - MemWrite = MemW & live
- While reset=0: PCSrc, RegWrite and MemWrite are 0, and Flags shows the stored value until the first edge, FLAG_RESET thereafter.
- CondEx itself is not masked by reset or Stall; it reflects the decode of the stored flags.
- Simultaneous events:
  - Reset beats Stall and flag writes.
  - Stall beats CondEx.
  - A failed condition suppresses both flag writes and all three strobes, even for compare instructions.
- Reset mid-instruction: the flag write in that cycle is lost; the register holds FLAG_RESET from the next edge.
- Unknown/X on Cond must not corrupt flags when FlagW=00.

Test Plan:
- Reset: hold reset=0 two cycles with FlagW=11, ALUFlags=1111, Cond=1110, RegW=1 -> Flags=0000, RegWrite=0. Release -> RegWrite=1 in the same cycle.
- CMP then BEQ:
  - Cycle 1: Cond=1110, FlagW=11, NoWrite=1, RegW=1, ALUFlags=0110 -> RegWrite=0; Flags=0110 after the edge.
  - Cycle 2: Cond=0000, PCS=1 -> CondEx=1, PCSrc=1.
  - Repeat with ALUFlags=1000 -> PCSrc=0.
- Partial write: from Flags=1111, apply FlagW=10, ALUFlags=0000, Cond=1110 -> Flags=0011; then FlagW=01, ALUFlags=0010 -> Flags=0010.
- Signed compares: for stored Flags 1001, 1000, 0100 and 0000, check GE/LT/GT/LE:
  - 1001 -> GE=1, GT=1
  - 1000 -> LT=1, LE=1
  - 0100 -> GE=1, GT=0, LE=1
  - 0000 -> GT=1
- Failed condition: stored Z=0, Cond=0000, FlagW=11, ALUFlags=0100, MemW=1 -> MemWrite=0; Flags unchanged after the edge.
- Stall: Cond=1110, FlagW=11, ALUFlags=1010, Stall=1 for 3 cycles -> Flags held and PCSrc/RegWrite/MemWrite=0. Drop Stall -> Flags=1010 after the next edge.
